// File: rtl/stream_cipher_pkg.sv
// Shared types and constants for the stream cipher datapath.
// The keystream LFSR step lives here so the hash generator and any consumer agree on it.
package stream_cipher_pkg;

  typedef enum logic [2:0] {
    GROUND,
    READY,
    LOADING_KEY,
    WARMUP,
    GENERATING
  } hash_generator_state_t;

  localparam logic [31:0] DefaultTaps = 32'h8020_0003;
  localparam logic [31:0] DefaultSeed = 32'h0000_0001;

  // Galois step: returns {next_lfsr, out_bit}.
  function automatic logic [32:0] lfsr_step(input logic [31:0] lfsr, input logic [31:0] taps);
    logic [31:0] nxt;
    nxt = lfsr >> 1;
    if (lfsr[0]) begin
      nxt = nxt ^ taps;
    end
    return {nxt, lfsr[0]};
  endfunction

endpackage

// File: rtl/hash_generator_if.sv
// Key/request/hash byte bundle between the keystream source and its consumer.
interface hash_generator_if;
  import stream_cipher_pkg::*;

  logic [7:0]            key_byte_in;
  logic                  key_byte_pulse;
  logic                  request_byte_pulse;
  logic [7:0]            hash_byte;
  logic                  hash_byte_pulse;
  hash_generator_state_t hash_generator_state;

  modport master (
    output key_byte_in, key_byte_pulse, request_byte_pulse,
    input  hash_byte, hash_byte_pulse, hash_generator_state
  );

  modport slave (
    input  key_byte_in, key_byte_pulse, request_byte_pulse,
    output hash_byte, hash_byte_pulse, hash_generator_state
  );

endinterface

// File: rtl/hash_generator.sv
// Keystream source: 32-bit Galois LFSR serving one hash byte per request,
// keyed byte-serially with an optional warm-up discard after each key load.
module hash_generator
  import stream_cipher_pkg::*;
#(
  parameter int unsigned LFSR_WIDTH    = 32,
  parameter logic [31:0] TAPS          = DefaultTaps,
  parameter logic [31:0] DEFAULT_SEED  = DefaultSeed,
  parameter int unsigned WARMUP_CYCLES = 64
) (
  input logic       clk,
  input logic       rst,
  hash_generator_if.slave hg_io
);

  localparam int unsigned WarmW       = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int unsigned WarmLastInt = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;
  localparam logic [WarmW-1:0] WarmLast = WarmW'(WarmLastInt);

  hash_generator_state_t state_q, state_d;

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [7:0]            sr_q, sr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [31:0]           key_sr_q, key_sr_d;
  logic [1:0]            key_cnt_q, key_cnt_d;
  logic [WarmW-1:0]      warm_cnt_q, warm_cnt_d;
  logic                  origin_ready_q, origin_ready_d;
  logic [7:0]            hash_byte_q, hash_byte_d;
  logic                  hash_pulse_q, hash_pulse_d;

  logic [32:0] step;
  logic [31:0] key_word;

  assign step     = lfsr_step(lfsr_q, TAPS);
  assign key_word = {key_sr_q[23:0], hg_io.key_byte_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GROUND;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    sr_d           = sr_q;
    bit_cnt_d      = bit_cnt_q;
    key_sr_d       = key_sr_q;
    key_cnt_d      = key_cnt_q;
    warm_cnt_d     = warm_cnt_q;
    origin_ready_d = origin_ready_q;
    hash_byte_d    = hash_byte_q;
    hash_pulse_d   = 1'b0;

    unique case (state_q)
      GROUND, READY: begin
        // A request takes priority; a coincident key byte is dropped.
        if (hg_io.request_byte_pulse) begin
          state_d        = GENERATING;
          bit_cnt_d      = 3'd0;
          origin_ready_d = (state_q == READY);
        end else if (hg_io.key_byte_pulse) begin
          state_d   = LOADING_KEY;
          key_sr_d  = key_word;
          key_cnt_d = 2'd1;
        end
      end
      LOADING_KEY: begin
        if (hg_io.key_byte_pulse) begin
          key_sr_d  = key_word;
          key_cnt_d = key_cnt_q + 2'd1;
          if (key_cnt_q == 2'd3) begin
            lfsr_d    = (key_word == 32'd0) ? DEFAULT_SEED : key_word;
            key_cnt_d = 2'd0;
            if (WARMUP_CYCLES == 0) begin
              state_d = READY;
            end else begin
              state_d    = WARMUP;
              warm_cnt_d = '0;
            end
          end
        end
      end
      WARMUP: begin
        lfsr_d     = step[32:1];
        warm_cnt_d = warm_cnt_q + WarmW'(1);
        if (warm_cnt_q == WarmLast) begin
          state_d = READY;
        end
      end
      GENERATING: begin
        lfsr_d    = step[32:1];
        sr_d      = {sr_q[6:0], step[0]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          hash_byte_d  = {sr_q[6:0], step[0]};
          hash_pulse_d = 1'b1;
          state_d      = origin_ready_q ? READY : GROUND;
        end
      end
      default: state_d = GROUND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q         <= DEFAULT_SEED;
      sr_q           <= 8'd0;
      bit_cnt_q      <= 3'd0;
      key_sr_q       <= 32'd0;
      key_cnt_q      <= 2'd0;
      warm_cnt_q     <= '0;
      origin_ready_q <= 1'b0;
      hash_byte_q    <= 8'd0;
      hash_pulse_q   <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      sr_q           <= sr_d;
      bit_cnt_q      <= bit_cnt_d;
      key_sr_q       <= key_sr_d;
      key_cnt_q      <= key_cnt_d;
      warm_cnt_q     <= warm_cnt_d;
      origin_ready_q <= origin_ready_d;
      hash_byte_q    <= hash_byte_d;
      hash_pulse_q   <= hash_pulse_d;
    end
  end

  assign hg_io.hash_byte            = hash_byte_q;
  assign hg_io.hash_byte_pulse      = hash_pulse_q;
  assign hg_io.hash_generator_state = state_q;

endmodule

// File: tb/tb_hash_generator.sv
// Bench for hash_generator: one instance without warm-up and one with the default 64-step
// warm-up, driven in lockstep and checked against a keystream model built from the LFSR rule.
module tb_hash_generator;
  import stream_cipher_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] key_byte = 8'd0;
  logic key_pulse = 1'b0;
  logic req_pulse = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m0, m64;
  logic [7:0] eb0, eb64;
  hash_generator_state_t es0, es64;

  always #5 clk = ~clk;

  hash_generator_if if0 ();
  hash_generator_if if64 ();

  assign if0.key_byte_in         = key_byte;
  assign if0.key_byte_pulse      = key_pulse;
  assign if0.request_byte_pulse  = req_pulse;
  assign if64.key_byte_in        = key_byte;
  assign if64.key_byte_pulse     = key_pulse;
  assign if64.request_byte_pulse = req_pulse;

  hash_generator #(.WARMUP_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .hg_io(if0));
  hash_generator u_dut64 (.clk(clk), .rst(rst), .hg_io(if64));

  typedef struct {
    logic [31:0] key;
    logic [7:0]  exp_byte;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: x^32+x^22+x^2+x+1 Galois stream, bits emitted LSB-first, packed MSB-first.
  function automatic logic [31:0] ref_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic ref_gen(inout logic [31:0] s, output logic [7:0] b);
    b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], s[0]};
      s = ref_next(s);
    end
  endtask

  task automatic model_reset();
    m0 = 32'd1; m64 = 32'd1; eb0 = 8'd0; eb64 = 8'd0; es0 = GROUND; es64 = GROUND;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(if0.hash_generator_state inside {GROUND, READY}) ||
           !(if64.hash_generator_state inside {GROUND, READY})) begin
      if (n >= 200) begin
        chk("idle_timeout", 32'(n), 32'd0);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic load_key(input logic [31:0] key);
    logic [31:0] k;
    wait_idle();
    k = key;
    for (int b = 0; b < 4; b++) begin
      key_byte = k[31:24];
      k = k << 8;
      key_pulse = 1'b1;
      tick();
      key_pulse = 1'b0;
    end
    m0 = (key == 32'd0) ? 32'd1 : key;
    m64 = m0;
    for (int i = 0; i < 64; i++) m64 = ref_next(m64);
    es0 = READY; es64 = READY;
    chk("key_state0", 32'(if0.hash_generator_state), 32'(READY));
    chk("key_state64", 32'(if64.hash_generator_state), 32'(WARMUP));
  endtask

  task automatic do_request(input bit with_key, output logic [7:0] got0);
    int lat;
    wait_idle();
    req_pulse = 1'b1;
    key_pulse = with_key;
    key_byte = 8'h5A;
    tick();
    req_pulse = 1'b0;
    key_pulse = 1'b0;
    chk("req_state0", 32'(if0.hash_generator_state), 32'(GENERATING));
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (if0.hash_byte_pulse) begin
        lat = n;
        break;
      end
    end
    ref_gen(m0, eb0);
    ref_gen(m64, eb64);
    got0 = if0.hash_byte;
    chk("latency", 32'(lat), 32'd8);
    chk("pulse64", 32'(if64.hash_byte_pulse), 32'd1);
    chk("byte0", 32'(if0.hash_byte), 32'(eb0));
    chk("byte64", 32'(if64.hash_byte), 32'(eb64));
    chk("origin0", 32'(if0.hash_generator_state), 32'(es0));
    chk("origin64", 32'(if64.hash_generator_state), 32'(es64));
    tick();
    chk("pulse_drop", 32'(if0.hash_byte_pulse), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    logic [7:0] got;
    int cnt, bad;

    vecs[0] = '{key: 32'h0000_0001, exp_byte: 8'hDB};
    vecs[1] = '{key: 32'h0000_0000, exp_byte: 8'hDB};
    vecs[2] = '{key: 32'h8020_0003, exp_byte: 8'hB6};
    vecs[3] = '{key: 32'hC030_0002, exp_byte: 8'h6D};

    tick();
    do_reset();
    chk("rst_state", 32'(if0.hash_generator_state), 32'(GROUND));
    chk("rst_byte", 32'(if0.hash_byte), 32'd0);
    chk("rst_pulse", 32'(if64.hash_byte_pulse), 32'd0);

    // First byte from the default seed, state traced cycle by cycle.
    req_pulse = 1'b1;
    tick();
    req_pulse = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (if0.hash_generator_state != GENERATING || if0.hash_byte_pulse) bad++;
      tick();
    end
    chk("gen_window", 32'(bad), 32'd0);
    chk("seed_pulse", 32'(if0.hash_byte_pulse), 32'd1);
    chk("seed_byte", 32'(if0.hash_byte), 32'hDB);
    chk("seed_state", 32'(if0.hash_generator_state), 32'(GROUND));
    ref_gen(m0, eb0);
    ref_gen(m64, eb64);
    tick();
    chk("seed_pulse_end", 32'(if0.hash_byte_pulse), 32'd0);

    // Key table: fixed first-byte expectations for the zero-warm-up instance.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      load_key(vecs[v].key);
      do_request(1'b0, got);
      chk($sformatf("table_byte%0d", v), 32'(got), 32'(vecs[v].exp_byte));
    end

    // Warm-up duration with no output activity.
    load_key(32'h1234_5678);
    cnt = 0; bad = 0;
    while (if64.hash_generator_state == WARMUP && cnt < 200) begin
      if (if64.hash_byte_pulse || if64.hash_byte != eb64) bad++;
      tick();
      cnt++;
    end
    chk("warm_cycles", 32'(cnt), 32'd64);
    chk("warm_quiet", 32'(bad), 32'd0);
    chk("warm_ready", 32'(if64.hash_generator_state), 32'(READY));
    do_request(1'b0, got);

    // Request and key pulses while generating are ignored.
    wait_idle();
    req_pulse = 1'b1;
    tick();
    req_pulse = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    req_pulse = 1'b1; key_pulse = 1'b1; key_byte = 8'hA5;
    tick();
    req_pulse = 1'b0; key_pulse = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (if0.hash_byte_pulse) cnt++;
      tick();
    end
    ref_gen(m0, eb0);
    ref_gen(m64, eb64);
    chk("ign_pulses", 32'(cnt), 32'd1);
    chk("ign_byte0", 32'(if0.hash_byte), 32'(eb0));
    chk("ign_byte64", 32'(if64.hash_byte), 32'(eb64));
    chk("ign_state", 32'(if0.hash_generator_state), 32'(READY));
    do_request(1'b0, got);

    // Simultaneous request and key byte in GROUND: request wins.
    do_reset();
    do_request(1'b1, got);
    chk("simul_byte", 32'(got), 32'hDB);

    // Reset abandons generation at step 4.
    req_pulse = 1'b1;
    tick();
    req_pulse = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("mid_rst_state", 32'(if0.hash_generator_state), 32'(GROUND));
    chk("mid_rst_byte", 32'(if0.hash_byte), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (if0.hash_byte_pulse || if64.hash_byte_pulse) cnt++;
      tick();
    end
    chk("mid_rst_quiet", 32'(cnt), 32'd0);
    do_request(1'b0, got);
    chk("post_rst_byte", 32'(got), 32'hDB);

    // Randomised mix of key loads and requests against the model.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        load_key(($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
      end else begin
        do_request(1'($urandom_range(0, 1)), got);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_generator.md
Name: hash_generator

Overview:
Keystream source for the stream cipher datapath. It sits directly upstream of the encryption block and serves one 8-bit hash byte per request pulse, produced by a 32-bit Galois LFSR stepped once per clock. It is keyed over a byte-serial interface and publishes its state so consumers know when a request will be accepted.

Parameters:
LFSR_WIDTH, 32, LFSR register width; fixed at 32, other values unsupported.
TAPS, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).
DEFAULT_SEED, 32'h0000_0001, LFSR value after reset; also substituted for an all-zero key.
WARMUP_CYCLES, 64, LFSR steps discarded after key load; 0 skips WARMUP.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
key_byte_in  in  8  key byte.
key_byte_pulse  in  1  one-cycle strobe, key_byte_in valid.
request_byte_pulse  in  1  one-cycle strobe requesting one hash byte.
hash_byte  out  8  last completed hash byte; held stable until the next byte completes.
hash_byte_pulse  out  1  one-cycle strobe, new hash_byte valid.
hash_generator_state  out  hash_generator_state_t  current FSM state.

Behaviour:
- Reset (rst sampled high on a clk edge): state=GROUND, lfsr=DEFAULT_SEED, hash_byte=0, hash_byte_pulse=0, all counters and key shift register=0. A reset mid-generation or mid-key-load abandons the operation and emits no pulse.
- LFSR step: out_bit=lfsr[0]; lfsr = lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1. The byte shift register captures out_bit MSB-first: sr={sr[6:0],out_bit}.
- States:
  - GROUND: idle on DEFAULT_SEED stream; requests accepted.
  - READY: idle on a keyed stream; requests accepted.
  - LOADING_KEY: collecting key bytes.
  - WARMUP: discarding LFSR output after key load.
  - GENERATING: producing a hash byte.
- GROUND/READY + request_byte_pulse -> GENERATING, bit_cnt=0; the origin state (GROUND or READY) is remembered.
- GENERATING: one step per cycle. On the 8th step, hash_byte<=sr (including the 8th bit), hash_byte_pulse<=1 for exactly one cycle, and the state returns to the origin. The pulse is high in the cycle after the 8th edge following the request-sampling edge, i.e. latency 8 cycles. The consumer may issue its next request from the pulse cycle onward.
- GROUND/READY + key_byte_pulse (no request) -> LOADING_KEY: key_sr={key_sr[23:0],key_byte_in}, key_cnt=1.
- LOADING_KEY: each further key_byte_pulse shifts a byte in. The first byte ends up in bits [31:24].
- On the 4th byte the LFSR is loaded: lfsr=(key==0)?DEFAULT_SEED:key.
  - WARMUP_CYCLES>0: -> WARMUP, cnt=0.
  - WARMUP_CYCLES=0: -> READY.
- WARMUP: one step per cycle. After WARMUP_CYCLES steps -> READY. sr and hash_byte are unchanged and no pulse is emitted.
- Ignored inputs:
  - request_byte_pulse in LOADING_KEY, WARMUP or GENERATING is ignored; no queueing, no pulse.
  - key_byte_pulse in WARMUP or GENERATING is ignored.
- Simultaneous request and key pulse in GROUND/READY: the request wins and the key byte is dropped.
- A new 4-byte key may be loaded from READY at any time and fully replaces the LFSR state. The stream is never reset except by rst.
- LFSR never holds zero.

Decomposition:
- Shared package stream_cipher_pkg:
  - typedef hash_generator_state_t {GROUND, READY, LOADING_KEY, WARMUP, GENERATING}, also consumed by the encryption block.
  - Default TAPS and DEFAULT_SEED constants.
  - Pure function lfsr_step returning {next_lfsr, out_bit}.
- No sub-module; the FSM, LFSR, byte shifter and counters stay in one 3-block FSM module.

Test Plan:
- Reset, then request_byte_pulse in GROUND -> state GENERATING for 8 cycles, then hash_byte=8'hDB with a single-cycle hash_byte_pulse 8 cycles after the sampling edge; state back to GROUND.
- WARMUP_CYCLES=0; key bytes 00,00,00,01 then request -> state READY after the 4th byte; hash_byte=8'hDB.
- WARMUP_CYCLES=0; key 00,00,00,00 -> zero-key substitution; first byte 8'hDB, identical to the previous scenario.
- Default WARMUP_CYCLES=64; load any key -> state WARMUP for exactly 64 cycles, then READY. No hash_byte_pulse and hash_byte unchanged throughout.
- request_byte_pulse during GENERATING, and key_byte_pulse during GENERATING -> both ignored: exactly one pulse, LFSR stream unchanged vs reference model.
- Request and key pulse in the same GROUND cycle -> GENERATING, key byte dropped. rst asserted at GENERATING step 4 -> next cycle GROUND, hash_byte=0, no pulse; a subsequent request yields 8'hDB.
